fsm_step_controller: RTL and testbench

- Sequences the one-hot and binary sequence-detector FSMs on the board.
- Turns a raw step pushbutton into clean single-cycle step pulses (manual mode), or generates periodic step pulses (auto-run mode).
- Captures the raw input switch into a stable `w_out` aligned to each step, and keeps a step counter for the LEDs.
- Both detector FSMs receive `step_en` and `w_out`, so they advance in lockstep.

---
 rtl/fsm_step_controller.sv | 211 +++++++++++++++++++++
 tb/tb_fsm_step_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_step_controller.sv
// -----------------------------------------------------------------------------
// fsm_step_controller
//
// Step sequencer for the sequence-detector FSMs on the board. It produces clean
// one-cycle step pulses, either from a debounced pushbutton (manual mode) or
// from a free-running prescaler (auto-run mode). The data switch is captured
// into w_out on every step, and a wrapping step counter drives the LEDs. Both
// detector FSMs consume step_en/w_out, so they advance in lockstep.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-low reset, clears all state
//   btn_step    in   raw step pushbutton, active-high, asynchronous
//   w_in        in   raw data switch, asynchronous
//   run         in   raw mode switch: 1 = auto-run, 0 = manual step
//   cnt_clr     in   raw clear request for step_count
//   step_en     out  one-cycle clock-enable pulse to the detector FSMs
//   w_out       out  detector input, updated on each step and held between steps
//   step_count  out  number of steps issued, mod 2^CNT_W
//   db_state    out  debounce FSM state (00 idle, 01 arm, 10 held, 11 release)
// -----------------------------------------------------------------------------
module fsm_step_controller #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned RUN_DIV   = 50000000,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_step,
    input  logic             w_in,
    input  logic             run,
    input  logic             cnt_clr,
    output logic             step_en,
    output logic             w_out,
    output logic [CNT_W-1:0] step_count,
    output logic [1:0]       db_state
);

    localparam int unsigned DCNT_W = $clog2(DB_CYCLES);
    localparam int unsigned PRE_W  = $clog2(RUN_DIV);

    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DB_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StArm  = 2'b01,
        StHeld = 2'b10,
        StRel  = 2'b11
    } db_state_e;

    // -------------------------------------------------------------------------
    // Input synchronizers, bit order {cnt_clr, run, w_in, btn_step}
    // -------------------------------------------------------------------------
    logic [3:0] sync1_d, sync1_q;
    logic [3:0] sync2_d, sync2_q;

    logic b_sync;
    logic w_sync;
    logic r_sync;
    logic c_sync;

    always_comb begin
        sync1_d = {cnt_clr, run, w_in, btn_step};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign b_sync = sync2_q[0];
    assign w_sync = sync2_q[1];
    assign r_sync = sync2_q[2];
    assign c_sync = sync2_q[3];

    // -------------------------------------------------------------------------
    // Debounce FSM: a press is accepted after the button is seen high for the
    // IDLE->ARM edge plus DB_CYCLES counting edges; a release needs the same
    // stable-low run before the FSM returns to IDLE.
    // -------------------------------------------------------------------------
    db_state_e          db_d, db_q;
    logic [DCNT_W-1:0]  dcnt_d, dcnt_q;
    logic               man_req;

    always_comb begin
        db_d    = db_q;
        dcnt_d  = dcnt_q;
        man_req = 1'b0;
        case (db_q)
            StIdle: begin
                if (b_sync) begin
                    db_d   = StArm;
                    dcnt_d = '0;
                end
            end
            StArm: begin
                if (!b_sync) begin
                    db_d = StIdle;
                end else if (dcnt_q == DCNT_MAX) begin
                    db_d    = StHeld;
                    man_req = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            StHeld: begin
                if (!b_sync) begin
                    db_d   = StRel;
                    dcnt_d = '0;
                end
            end
            StRel: begin
                // A bounce during release goes back to HELD without a new step.
                if (b_sync) begin
                    db_d = StHeld;
                end else if (dcnt_q == DCNT_MAX) begin
                    db_d = StIdle;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: begin
                db_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q   <= StIdle;
            dcnt_q <= '0;
        end else begin
            db_q   <= db_d;
            dcnt_q <= dcnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Auto-run prescaler: held at zero while not running, so the first auto
    // step lands exactly RUN_DIV cycles after run is seen high.
    // -------------------------------------------------------------------------
    logic [PRE_W-1:0] pre_d, pre_q;
    logic             auto_req;

    always_comb begin
        auto_req = r_sync && (pre_q == PRE_MAX);
        if (!r_sync) begin
            pre_d = '0;
        end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // -------------------------------------------------------------------------
    // Step issue: mode selects the request source; manual requests are ignored
    // while running even though the debounce FSM keeps tracking the button.
    // -------------------------------------------------------------------------
    logic             step_req;
    logic             step_en_d, step_en_q;
    logic             w_out_d, w_out_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        step_req  = r_sync ? auto_req : man_req;
        step_en_d = step_req;
        w_out_d   = step_req ? w_sync : w_out_q;
        // Clear wins over a same-cycle increment.
        if (c_sync) begin
            cnt_d = '0;
        end else if (step_req) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_en_q <= 1'b0;
            w_out_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            step_en_q <= step_en_d;
            w_out_q   <= w_out_d;
            cnt_q     <= cnt_d;
        end
    end

    assign step_en    = step_en_q;
    assign w_out      = w_out_q;
    assign step_count = cnt_q;
    assign db_state   = db_q;

endmodule

// File: tb/tb_fsm_step_controller.sv
module tb_fsm_step_controller;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic          btn_step;
    logic          w_in;
    logic          run;
    logic          cnt_clr;
    logic          step_en;
    logic          w_out;
    logic [CW-1:0] step_count;
    logic [1:0]    db_state;

    fsm_step_controller #(
        .DB_CYCLES(DB),
        .RUN_DIV  (RD),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_step  (btn_step),
        .w_in      (w_in),
        .run       (run),
        .cnt_clr   (cnt_clr),
        .step_en   (step_en),
        .w_out     (w_out),
        .step_count(step_count),
        .db_state  (db_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: inputs delayed two edges, a press accepted after
    // DB+1 consecutive high samples, a release after DB+1 consecutive low
    // samples, auto steps every RD-th consecutive run-high sample.
    // ------------------------------------------------------------------
    bit [1:0] mb, mw, mr, mc;
    int       hi_run, lo_run, r_run;
    bit       held;
    bit       ms, mman, maut;
    bit       m_step_en, m_w_out;
    int       m_cnt;
    int       m_db;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mb = 0; mw = 0; mr = 0; mc = 0;
            hi_run = 0; lo_run = 0; r_run = 0; held = 0;
            m_step_en = 0; m_w_out = 0; m_cnt = 0;
        end else begin
            mman = 0;
            if (!held) begin
                hi_run = mb[1] ? hi_run + 1 : 0;
                if (hi_run == DB + 1) begin
                    mman = 1; held = 1; hi_run = 0;
                end
            end else begin
                lo_run = mb[1] ? 0 : lo_run + 1;
                if (lo_run == DB + 1) begin
                    held = 0; lo_run = 0;
                end
            end
            r_run = mr[1] ? r_run + 1 : 0;
            maut = mr[1] && (r_run % RD == 0);
            ms = mr[1] ? maut : mman;
            m_step_en = ms;
            if (ms) m_w_out = mw[1];
            if (mc[1]) m_cnt = 0;
            else if (ms) m_cnt = (m_cnt + 1) % (1 << CW);
            mb = {mb[0], btn_step};
            mw = {mw[0], w_in};
            mr = {mr[0], run};
            mc = {mc[0], cnt_clr};
        end
        if (!held) m_db = (hi_run == 0) ? 0 : 1;
        else       m_db = (lo_run == 0) ? 2 : 3;
    end

    // Cycle counter and pulse log
    int cyc = 0;
    int npulse = 0;
    int pulse_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        check("step_en", int'(step_en), int'(m_step_en));
        check("w_out", int'(w_out), int'(m_w_out));
        check("step_count", int'(step_count), m_cnt);
        check("db_state", int'(db_state), m_db);
        if (step_en) begin
            npulse++;
            pulse_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int p0, q0, c0;

    initial begin
        reset = 0; btn_step = 0; w_in = 0; run = 0; cnt_clr = 0;
        tick(3);
        check("rst_step_en", int'(step_en), 0);
        check("rst_count", int'(step_count), 0);
        check("rst_db_state", int'(db_state), 0);
        reset = 1;
        tick(2);

        // Held press, w_in=1
        btn_step = 1; w_in = 1;
        tick(6);
        check("t1_no_early_pulse", int'(step_en), 0);
        check("t1_arm", int'(db_state), 1);
        tick(1);
        check("t1_pulse", int'(step_en), 1);
        check("t1_w_out", int'(w_out), 1);
        check("t1_count", int'(step_count), 1);
        check("t1_held", int'(db_state), 2);
        tick(1);
        check("t1_one_cycle", int'(step_en), 0);
        tick(5);
        check("t1_still_held", int'(db_state), 2);
        btn_step = 0; tick(1); btn_step = 1; tick(1); btn_step = 0; w_in = 0;
        tick(12);
        check("t1_release_no_step", npulse, 1);
        check("t1_idle", int'(db_state), 0);
        check("t1_w_hold", int'(w_out), 1);

        // Bouncy press
        btn_step = 1; tick(2); btn_step = 0; tick(1); btn_step = 1;
        tick(6);
        check("t2_no_early_pulse", int'(step_en), 0);
        tick(1);
        check("t2_pulse", int'(step_en), 1);
        check("t2_w_out", int'(w_out), 0);
        check("t2_count", int'(step_count), 2);
        tick(4);
        btn_step = 0; tick(1); btn_step = 1; tick(1); btn_step = 0;
        tick(12);
        check("t2_total_pulses", npulse, 2);
        check("t2_idle", int'(db_state), 0);

        // Auto-run with w toggling and a suppressed button press
        p0 = npulse; q0 = pulse_cyc.size(); c0 = cyc;
        run = 1;
        for (int i = 1; i <= 35; i++) begin
            tick(1);
            w_in = ~w_in;
            if (i == 14) btn_step = 1;
            if (i == 30) btn_step = 0;
        end
        run = 0;
        tick(15);
        check("t3_pulses", npulse - p0, 3);
        if (pulse_cyc.size() >= q0 + 3) begin
            check("t3_first_at_10", pulse_cyc[q0] - c0, 12);
            check("t3_spacing_a", pulse_cyc[q0 + 1] - pulse_cyc[q0], 10);
            check("t3_spacing_b", pulse_cyc[q0 + 2] - pulse_cyc[q0 + 1], 10);
        end else begin
            check("t3_pulse_log_size", pulse_cyc.size() - q0, 3);
        end
        check("t3_count", int'(step_count), 5);
        check("t3_idle", int'(db_state), 0);

        // Clear, preload 255 steps, wrap, clear coincident with a step
        cnt_clr = 1; tick(3);
        check("t4_clr", int'(step_count), 0);
        cnt_clr = 0; tick(3);
        p0 = npulse;
        run = 1;
        tick(2552);
        check("t4_count_255", int'(step_count), 255);
        run = 0;
        tick(10);
        check("t4_preload_pulses", npulse - p0, 255);
        btn_step = 1; tick(7);
        check("t4_wrap_pulse", int'(step_en), 1);
        check("t4_wrap_count", int'(step_count), 0);
        btn_step = 0; tick(12);
        btn_step = 1; tick(7);
        check("t4_count_1", int'(step_count), 1);
        btn_step = 0; tick(12);
        btn_step = 1; tick(4);
        cnt_clr = 1; tick(1);
        cnt_clr = 0; tick(2);
        check("t4_clr_pulse", int'(step_en), 1);
        check("t4_clr_count", int'(step_count), 0);
        btn_step = 0; tick(12);

        // Reset in the middle of ARM with button held through release
        btn_step = 1; tick(5);
        check("t5_arm", int'(db_state), 1);
        #1 reset = 0;
        #1;
        check("t5_async_db", int'(db_state), 0);
        check("t5_async_w_out", int'(w_out), 0);
        check("t5_async_step", int'(step_en), 0);
        tick(2);
        reset = 1;
        tick(6);
        check("t5_no_early_pulse", int'(step_en), 0);
        tick(1);
        check("t5_pulse", int'(step_en), 1);
        check("t5_w_out", int'(w_out), 1);
        check("t5_count", int'(step_count), 1);
        btn_step = 0; tick(12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
